// File: rtl/debug_ctrl_param.sv
// debug_ctrl_param: UART-driven debug controller for the MIPS pipeline.
//
// Decodes single-byte commands from the UART receiver and gates the datapath
// through a clock enable (continuous run, single step, or datapath reset).
// After every step/run/dump request it captures the datapath state bus into a
// shadow register and streams it out byte-by-byte, LSB byte first, through
// the UART transmitter.
//
// Commands: 'R' 0x52 reset datapath, 'S' 0x53 single step, 'C' 0x43 run,
//           'D' 0x44 dump only, 'P' 0x50 pause (only meaningful in RUN).
//
// Optional feature macro: DEBUG_CYCLE_CNT_EN
//   defined   - a CNT_W-bit total enabled-cycle counter is captured with the
//               snapshot and appended to the dump (CNT_W/8 extra bytes).
//   undefined - no counter; the dump is exactly DATA_W/8 bytes.
//
// Parameters:
//   DATA_W    width of the snapshot bus (multiple of 8)
//   RUN_LIMIT watchdog: max enabled cycles in one continuous run (>= 1)
//   CNT_W     width of the total-cycle counter (multiple of 8)
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   rx_done_tick  pulse: rx_bus holds a received byte
//   rx_bus        received byte
//   tx_done_tick  pulse: transmitter finished the current byte
//   dp_halt       datapath retired a HALT instruction
//   dp_bus        datapath state snapshot
//   dp_clk_en     datapath clock enable
//   dp_reset      datapath synchronous reset
//   tx_write      pulse: start transmitting tx_bus
//   tx_bus        byte to transmit (registered)

module debug_ctrl_param #(
    parameter int unsigned DATA_W    = 1376,
    parameter int unsigned RUN_LIMIT = 65535,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_bus,
    input  logic              tx_done_tick,
    input  logic              dp_halt,
    input  logic [DATA_W-1:0] dp_bus,
    output logic              dp_clk_en,
    output logic              dp_reset,
    output logic              tx_write,
    output logic [7:0]        tx_bus
);

    if ((DATA_W % 8) != 0 || (CNT_W % 8) != 0 || RUN_LIMIT == 0) begin : g_param_check
        $error("debug_ctrl_param: DATA_W/CNT_W must be multiples of 8 and RUN_LIMIT >= 1");
    end

`ifdef DEBUG_CYCLE_CNT_EN
    localparam int unsigned DUMP_W = DATA_W + CNT_W;
`else
    localparam int unsigned DUMP_W = DATA_W;
`endif
    localparam int unsigned DUMP_BYTES = DUMP_W / 8;
    localparam int unsigned IDX_W      = (DUMP_BYTES > 1) ? $clog2(DUMP_BYTES) : 1;
    localparam int unsigned RUN_W      = $clog2(RUN_LIMIT + 1);

    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(DUMP_BYTES - 1);
    localparam logic [RUN_W-1:0] RunLimit = RUN_W'(RUN_LIMIT);

    localparam logic [7:0] CmdReset = 8'h52;
    localparam logic [7:0] CmdStep  = 8'h53;
    localparam logic [7:0] CmdCont  = 8'h43;
    localparam logic [7:0] CmdDump  = 8'h44;
    localparam logic [7:0] CmdPause = 8'h50;

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StRun,
        StCapture,
        StSend,
        StWait
    } state_e;

    state_e              state_q, state_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [RUN_W-1:0]    run_cnt_inc;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DUMP_W-1:0]   shadow_q, shadow_d;
    logic [DUMP_W-1:0]   shadow_shift;
    logic [DUMP_W-1:0]   capture_vec;
    logic [7:0]          tx_bus_q, tx_bus_d;
    logic                dp_reset_q, dp_reset_d;

`ifdef DEBUG_CYCLE_CNT_EN
    logic [CNT_W-1:0]    cyc_cnt_q;
    logic                cyc_clr;

    assign cyc_clr     = (state_q == StIdle) && rx_done_tick && (rx_bus == CmdReset);
    // Counter sits above the snapshot so it goes out after the snapshot bytes.
    assign capture_vec = {cyc_cnt_q, dp_bus};

    // Counts every enabled datapath cycle; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset || cyc_clr) begin
            cyc_cnt_q <= '0;
        end else if (dp_clk_en) begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
        end
    end
`else
    assign capture_vec = dp_bus;
`endif

    // The run counter includes the current cycle, so the watchdog exits after
    // exactly RUN_LIMIT enabled cycles.
    assign run_cnt_inc  = run_cnt_q + 1'b1;
    // Shift-out register: the next byte to send always sits in the low byte.
    assign shadow_shift = shadow_q >> 8;

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        tx_bus_d   = tx_bus_q;
        dp_reset_d = 1'b0;
        dp_clk_en  = 1'b0;
        tx_write   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_done_tick) begin
                    case (rx_bus)
                        CmdReset: dp_reset_d = 1'b1;
                        CmdStep:  state_d = StStep;
                        CmdCont: begin
                            state_d   = StRun;
                            run_cnt_d = '0;
                        end
                        CmdDump:  state_d = StCapture;
                        default:  ;
                    endcase
                end
            end
            StStep: begin
                dp_clk_en = 1'b1;
                state_d   = StCapture;
            end
            StRun: begin
                dp_clk_en = 1'b1;
                run_cnt_d = run_cnt_inc;
                if (dp_halt || (rx_done_tick && (rx_bus == CmdPause)) ||
                    (run_cnt_inc == RunLimit)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                shadow_d = capture_vec;
                tx_bus_d = capture_vec[7:0];
                idx_d    = '0;
                state_d  = StSend;
            end
            StSend: begin
                tx_write = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (tx_done_tick) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        shadow_d = shadow_shift;
                        tx_bus_d = shadow_shift[7:0];
                        state_d  = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            run_cnt_q  <= '0;
            idx_q      <= '0;
            tx_bus_q   <= '0;
            dp_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            idx_q      <= idx_d;
            tx_bus_q   <= tx_bus_d;
            dp_reset_q <= dp_reset_d;
        end
    end

    // Snapshot data needs no reset: it is always loaded in CAPTURE before use.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign dp_reset = dp_reset_q;
    assign tx_bus   = tx_bus_q;

endmodule

// File: tb/tb_debug_ctrl_param.sv
module tb_debug_ctrl_param;

    localparam int DATA_W = 1376;
    localparam int SNAP   = DATA_W / 8;
`ifdef DEBUG_CYCLE_CNT_EN
    localparam int DUMP = SNAP + 4;
`else
    localparam int DUMP = SNAP;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_done_tick;
    logic [7:0]        rx_bus;
    logic              tx_done_tick;
    logic              dp_halt;
    logic [DATA_W-1:0] dp_bus;
    logic              dp_clk_en;
    logic              dp_reset;
    logic              tx_write;
    logic [7:0]        tx_bus;

    debug_ctrl_param #(
        .DATA_W   (DATA_W),
        .RUN_LIMIT(20),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .rx_done_tick(rx_done_tick),
        .rx_bus      (rx_bus),
        .tx_done_tick(tx_done_tick),
        .dp_halt     (dp_halt),
        .dp_bus      (dp_bus),
        .dp_clk_en   (dp_clk_en),
        .dp_reset    (dp_reset),
        .tx_write    (tx_write),
        .tx_bus      (tx_bus)
    );

    always #5 clk = ~clk;

    // Monitor / UART tx responder (negedge sampling)
    logic [7:0] got[$];
    int wr_cnt  = 0;
    int en_cnt  = 0;
    int overlap = 0;
    int stop_at = 0;
    int cd      = 0;
    bit busy    = 0;

    initial tx_done_tick = 1'b0;

    always @(negedge clk) begin
        tx_done_tick = 1'b0;
        if (rst !== 1'b1 && dp_clk_en === 1'b1) en_cnt++;
        if (rst === 1'b1) begin
            busy = 0;
            cd   = 0;
        end else if (tx_write === 1'b1) begin
            got.push_back(tx_bus);
            wr_cnt++;
            if (busy) overlap++;
            busy = 1;
            cd   = 3;
        end else if (busy && (stop_at == 0 || wr_cnt != stop_at)) begin
            cd--;
            if (cd == 0) begin
                tx_done_tick = 1'b1;
                busy = 0;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_bus       = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rx_bus       = 8'h00;
    endtask

    task automatic wait_wr(input int target);
        int budget = 5000;
        while (wr_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (12) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [DATA_W-1:0] bus,
                                            input logic [31:0] cnt);
        if (i < SNAP) return bus[8*i +: 8];
        return cnt[8*(i-SNAP) +: 8];
    endfunction

    task automatic check_dump(input string tag, input int base, input logic [DATA_W-1:0] bus,
                              input logic [31:0] cnt);
        logic [7:0] obs;
        check({tag, "_len"}, wr_cnt, base + DUMP);
        for (int i = 0; i < DUMP; i++) begin
            obs = (base + i < got.size()) ? got[base + i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), {24'h0, obs}, {24'h0, exp_byte(i, bus, cnt)});
        end
        check({tag, "_overlap"}, overlap, 0);
    endtask

    logic [DATA_W-1:0] pat_a, pat_b;
    int w0, e0, w1;

    initial begin
        for (int i = 0; i < SNAP; i++) begin
            pat_a[8*i +: 8] = 8'(i);
            pat_b[8*i +: 8] = 8'(255 - i);
        end
        rst = 1'b1; rx_done_tick = 1'b0; rx_bus = 8'h00; dp_halt = 1'b0; dp_bus = pat_a;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_dp_reset", dp_reset, 1);
            check("rst_clk_en", dp_clk_en, 0);
            check("rst_tx_write", tx_write, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_dp_reset", dp_reset, 0);
        check("post_rst_clk_en", dp_clk_en, 0);
        repeat (5) @(negedge clk);
        check("post_rst_no_tx", wr_cnt, 0);

        // Single step: STEP, CAPTURE, SEND
        w0 = wr_cnt; e0 = en_cnt;
        send_byte(8'h53);
        check("step_en", dp_clk_en, 1);
        check("step_tx0", tx_write, 0);
        @(negedge clk);
        check("cap_en", dp_clk_en, 0);
        check("cap_tx0", tx_write, 0);
        @(negedge clk);
        check("send_tx1", tx_write, 1);
        check("send_byte0", tx_bus, 8'h00);
        wait_wr(w0 + DUMP);
        check_dump("step", w0, pat_a, 32'd1);
        check("step_en_cycles", en_cnt - e0, 1);

        // 'R' pulse, then run until halt after 10 enabled cycles
        send_byte(8'h52);
        check("r_pulse_hi", dp_reset, 1);
        @(negedge clk);
        check("r_pulse_lo", dp_reset, 0);
        dp_bus = pat_b;
        w0 = wr_cnt; e0 = en_cnt;
        send_byte(8'h43);
        repeat (10) @(negedge clk);
        check("halt_run_en", dp_clk_en, 1);
        dp_halt = 1'b1;
        @(negedge clk);
        dp_halt = 1'b0;
        check("halt_stop_en", dp_clk_en, 0);
        wait_wr(w0 + DUMP);
        check("halt_en_cycles", en_cnt - e0, 11);
        check_dump("halt", w0, pat_b, 32'd11);

        // Pause after 5 enabled cycles
        dp_bus = pat_a;
        w0 = wr_cnt; e0 = en_cnt;
        send_byte(8'h43);
        repeat (4) @(negedge clk);
        send_byte(8'h50);
        check("pause_stop_en", dp_clk_en, 0);
        wait_wr(w0 + DUMP);
        check("pause_en_cycles", en_cnt - e0, 5);
        check_dump("pause", w0, pat_a, 32'd16);

        // Watchdog at RUN_LIMIT=20; 'P' during dump ignored
        dp_bus = pat_b;
        w0 = wr_cnt; e0 = en_cnt;
        send_byte(8'h43);
        repeat (19) @(negedge clk);
        check("limit_last_en", dp_clk_en, 1);
        @(negedge clk);
        check("limit_stop_en", dp_clk_en, 0);
        begin
            int budget = 500;
            while (wr_cnt < w0 + 5 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
        end
        send_byte(8'h50);
        wait_wr(w0 + DUMP);
        check("limit_en_cycles", en_cnt - e0, 20);
        check_dump("limit", w0, pat_b, 32'd36);

        // 'R', ignored 0x41, then 'D' (2-cycle latency, counter 0)
        send_byte(8'h52);
        check("r2_pulse_hi", dp_reset, 1);
        @(negedge clk);
        w0 = wr_cnt; e0 = en_cnt;
        send_byte(8'h41);
        repeat (5) @(negedge clk);
        check("ign_dp_reset", dp_reset, 0);
        check("ign_no_tx", wr_cnt, w0);
        check("ign_no_en", en_cnt, e0);
        dp_bus = pat_a;
        send_byte(8'h44);
        check("dump_lat_tx0", tx_write, 0);
        @(negedge clk);
        check("dump_lat_tx1", tx_write, 1);
        check("dump_lat_byte0", tx_bus, 8'h00);
        wait_wr(w0 + DUMP);
        check_dump("dumpr", w0, pat_a, 32'd0);
        check("dumpr_no_en", en_cnt, e0);

        // Reset during WAIT at byte 50
        dp_bus  = pat_b;
        w0      = wr_cnt;
        stop_at = w0 + 51;
        send_byte(8'h44);
        wait_wr(w0 + 51);
        check("stall_cnt", wr_cnt, w0 + 51);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stop_at = 0;
        w1 = wr_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_tx", wr_cnt, w1);
        check("abort_tx_write", tx_write, 0);
        check("abort_clk_en", dp_clk_en, 0);
        send_byte(8'h44);
        wait_wr(w1 + DUMP);
        check_dump("redump", w1, pat_b, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_ctrl_param.md
Name: debug_ctrl_param

Overview:
UART-driven debug controller for the MIPS pipeline, parametrised in snapshot width.
- Decodes single-byte commands from the UART receiver.
- Gates datapath execution through a clock enable: continuous run, single step, or reset.
- Captures a snapshot of the datapath state bus and streams it back byte-by-byte through the UART transmitter.
- Sits between the UART rx/tx pair and the datapath top level.

Parameters:
DATA_W, 1376, width of datapath snapshot bus; must be a multiple of 8 (SNAP_BYTES = DATA_W/8 = 172).
RUN_LIMIT, 65535, maximum enabled cycles in one continuous run before forced stop (watchdog).
CNT_W, 32, width of total-cycle counter; multiple of 8.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
rx_done_tick  in  1  one-cycle pulse: rx_bus holds a valid received byte
rx_bus  in  8  received byte
tx_done_tick  in  1  one-cycle pulse: transmitter finished current byte
dp_halt  in  1  datapath reports HALT instruction retired
dp_bus  in  DATA_W  datapath state snapshot
dp_clk_en  out  1  datapath clock enable
dp_reset  out  1  datapath synchronous reset
tx_write  out  1  one-cycle pulse: start transmitting tx_bus
tx_bus  out  8  byte to transmit (registered)

Behaviour:
- Reset values: state IDLE, dp_clk_en=0, dp_reset=1 while reset high, tx_write=0, tx_bus=0, all counters 0. Reset mid-dump or mid-run aborts immediately; no further tx_write.
- Commands are sampled only when rx_done_tick=1:
  - 0x52 'R': reset datapath.
  - 0x53 'S': single step.
  - 0x43 'C': continuous run.
  - 0x44 'D': dump without executing.
  - 0x50 'P': pause; valid only in RUN.
  - All other bytes are ignored.
- IDLE:
  - dp_clk_en=0.
  - 'R': dp_reset=1 for exactly one cycle; total-cycle counter cleared; stay IDLE.
  - 'S' -> STEP. 'C' -> RUN (run counter cleared). 'D' -> CAPTURE.
- STEP: dp_clk_en=1 for exactly one cycle, then -> CAPTURE.
- RUN:
  - dp_clk_en=1 every cycle; run counter increments.
  - Exit to CAPTURE, with dp_clk_en=0 from the next cycle, when any of these holds: dp_halt=1, 'P' received, or run counter == RUN_LIMIT.
  - If several exit conditions occur in the same cycle, a single exit is taken.
  - The cycle in which dp_halt is sampled high is itself enabled; there are no extra enabled cycles after it.
- CAPTURE: one cycle; dp_bus latched into shadow register; byte index=0 -> SEND.
- SEND: tx_bus = shadow[8*idx+7 : 8*idx] (LSB byte first); tx_write pulses for 1 cycle -> WAIT.
- WAIT:
  - On tx_done_tick: idx+1. If idx == last byte -> IDLE, else -> SEND.
  - tx_done_tick outside WAIT is ignored.
- rx bytes received in STEP/CAPTURE/SEND/WAIT are dropped; no queueing.
- Total-cycle counter: increments on every cycle with dp_clk_en=1; wraps modulo 2^CNT_W; cleared only by reset or 'R'.
- Latency: command byte to first tx_write = 3 cycles for 'S' (STEP, CAPTURE, SEND), 2 cycles for 'D'.

Optional Feature:
DEBUG_CYCLE_CNT_EN
- Defined: the total-cycle counter is latched together with the snapshot in CAPTURE. The dump is extended by CNT_W/8 bytes after the snapshot bytes, LSB first (176 bytes total at defaults).
- Undefined: the counter logic is absent, and the dump is exactly SNAP_BYTES bytes.

Test Plan:
- Reset held 3 cycles, then released -> dp_reset=1 during reset, 0 after; dp_clk_en=0; tx_write=0; no bytes sent.
- Send 'S' with dp_bus=incrementing byte pattern 0x00..0xAB -> exactly one dp_clk_en cycle; 172 tx_write pulses carrying 0x00,0x01,...,0xAB in order; each pulse only after a tx_done_tick.
- Send 'C', assert dp_halt after 10 enabled cycles -> exactly 11 dp_clk_en cycles including the halt cycle; dump follows; with DEBUG_CYCLE_CNT_EN the last 4 bytes are 0x0B,0x00,0x00,0x00.
- Send 'C' with RUN_LIMIT=20 and dp_halt=0 -> dp_clk_en high for 20 cycles; dump starts; a 'P' sent during the dump is ignored.
- Send 'R' -> one-cycle dp_reset pulse; cycle counter reads 0 in the next 'D' dump; the byte 0x41 is ignored with no state change.
- Assert reset during WAIT at byte 50 -> tx_write stays 0 afterwards; state IDLE; a new 'D' dump starts again from byte 0.
